// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, datapath width and
// the divide-by-zero quotient constant.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 64;

    localparam logic [ALU_WIDTH-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and select the result.
module div_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next,
    output logic             borrow
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Full WIDTH+1-bit shift so divisors above 2^(WIDTH-1) stay exact
    assign shifted  = {rem, q[WIDTH-1]};
    assign trial    = shifted - {1'b0, divisor};
    assign borrow   = trial[WIDTH];
    assign rem_next = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_next   = {q[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/alu_div_sequencer.sv
// Multi-cycle restoring divider controller with valid/ready handshakes.
// Optional signed support is enabled by defining ALU_DIV_SIGNED_EN.
module alu_div_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] step_rem, step_q;
    logic             unused_borrow;

`ifdef ALU_DIV_SIGNED_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;
    logic sgn_a, sgn_b;
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (rem_q),
        .q        (q_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_next   (step_q),
        .borrow   (unused_borrow)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
`ifdef ALU_DIV_SIGNED_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        sgn_a   = is_signed & dividend[WIDTH-1];
        sgn_b   = is_signed & divisor[WIDTH-1];
`endif
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            state_d = DONE;
                            q_d     = WIDTH'(DIV_ZERO_Q);
                            rem_d   = dividend;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d = RUN;
                            count_d = CNT_W'(WIDTH - 1);
                            rem_d   = '0;
                            dbz_d   = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
                            // Iterate on magnitudes; signs are restored on the last step
                            q_d     = sgn_a ? -dividend : dividend;
                            dvs_d   = sgn_b ? -divisor : divisor;
                            neg_q_d = sgn_a ^ sgn_b;
                            neg_r_d = sgn_a;
`else
                            q_d     = dividend;
                            dvs_d   = divisor;
`endif
                        end
                    end
                end
                RUN: begin
                    q_d   = step_q;
                    rem_d = step_rem;
                    if (count_q == '0) begin
                        state_d = DONE;
`ifdef ALU_DIV_SIGNED_EN
                        if (neg_q_q) q_d = -step_q;
                        if (neg_r_q) rem_d = -step_rem;
`endif
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef ALU_DIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end
`endif

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = q_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Self-checking bench for alu_div_sequencer: a transaction-level model plus
// directed vectors with literal expectations.
module tb_alu_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    alu_div_sequencer #(
        .WIDTH (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: quotient/remainder from the divide rules.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic z);
        logic [63:0] ma, mb;
        logic        na, nb;
        z = (b == 64'd0);
`ifdef ALU_DIV_SIGNED_EN
        na = s & a[63];
        nb = s & b[63];
`else
        na = 1'b0;
        nb = 1'b0;
`endif
        if (z) begin
            q = '1;
            r = a;
        end else begin
            ma = na ? -a : a;
            mb = nb ? -b : b;
            q  = ma / mb;
            r  = ma % mb;
            if (na ^ nb) q = -q;
            if (na) r = -r;
        end
    endfunction

    // Transaction model: one outstanding request, result ready after a fixed latency.
    longint unsigned cyc = 0;
    longint unsigned m_ready = 0;
    logic            m_pend = 1'b0;
    logic [63:0]     m_q = '0, m_r = '0;
    logic            m_dbz = 1'b0;
    logic [63:0]     t_q, t_r;
    logic            t_z;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (flush) begin
                m_pend <= 1'b0;
            end else if (!m_pend && in_valid) begin
                model(dividend, divisor, is_signed, t_q, t_r, t_z);
                m_q     <= t_q;
                m_r     <= t_r;
                m_dbz   <= t_z;
                m_pend  <= 1'b1;
                m_ready <= cyc + ((divisor == 64'd0) ? 1 : 65);
            end else if (m_pend && cyc >= m_ready && out_ready) begin
                m_pend <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_v;
        if (rst_n) begin
            exp_v = m_pend && (cyc >= m_ready);
            chk("cyc_in_ready", {63'd0, in_ready}, {63'd0, !m_pend});
            chk("cyc_busy", {63'd0, busy}, {63'd0, m_pend});
            chk("cyc_out_valid", {63'd0, out_valid}, {63'd0, exp_v});
            if (exp_v && out_valid) begin
                chk("cyc_quotient", quotient, m_q);
                chk("cyc_remainder", remainder, m_r);
                chk("cyc_div_by_zero", {63'd0, div_by_zero}, {63'd0, m_dbz});
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s);
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; returns edges from accept to out_valid.
    task automatic wait_valid(output int lat);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_mis++;
            $display("FAIL wait_valid: timeout after %0d cycles", n);
        end
        lat = n + 1;
    endtask

    task automatic finish_one();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_dbz"}, {63'd0, div_by_zero}, 64'd0);
        chk({tag, "_quotient"}, quotient, 64'd0);
        chk({tag, "_remainder"}, remainder, 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [63:0] hold_q, hold_r;

        #1 chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 100 / 7
        send(64'd100, 64'd7, 1'b0);
        wait_valid(lat);
        chk("u100_7_lat", 64'(lat), 64'd65);
        chk("u100_7_q", quotient, 64'd14);
        chk("u100_7_r", remainder, 64'd2);
        chk("u100_7_dbz", {63'd0, div_by_zero}, 64'd0);
        finish_one();

        // all-ones / 1
        send('1, 64'd1, 1'b0);
        wait_valid(lat);
        chk("max_1_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("max_1_r", remainder, 64'd0);
        finish_one();

        // large divisor exercises the top remainder bit
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hC000_0000_0000_0000, 1'b0);
        wait_valid(lat);
        chk("bigdiv_q", quotient, 64'd1);
        chk("bigdiv_r", remainder, 64'h3FFF_FFFF_FFFF_FFFF);
        finish_one();

        // 55 / 0
        send(64'd55, 64'd0, 1'b0);
        wait_valid(lat);
        chk("dz_lat", 64'(lat), 64'd1);
        chk("dz_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("dz_r", remainder, 64'd55);
        chk("dz_flag", {63'd0, div_by_zero}, 64'd1);
        finish_one();

        // Backpressure, with the next request already waiting
        out_ready = 1'b0;
        send(64'd1000, 64'd10, 1'b0);
        wait_valid(lat);
        hold_q = quotient;
        hold_r = remainder;
        in_valid = 1'b1;
        dividend = 64'd20;
        divisor  = 64'd6;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("bp_q_stable", quotient, hold_q);
        chk("bp_r_stable", remainder, hold_r);
        chk("bp_q", quotient, 64'd100);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_bubble_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_next_busy", {63'd0, busy}, 64'd1);
        wait_valid(lat);
        chk("bp_next_lat", 64'(lat), 64'd65);
        chk("bp_next_q", quotient, 64'd3);
        chk("bp_next_r", remainder, 64'd2);
        finish_one();

        // Flush on RUN cycle 20
        send(64'd12345, 64'd7, 1'b0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("fl_busy", {63'd0, busy}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("fl_no_valid", 64'(seen), 64'd0);
        send(64'd9, 64'd3, 1'b0);
        wait_valid(lat);
        chk("fl_9_3_q", quotient, 64'd3);
        chk("fl_9_3_r", remainder, 64'd0);
        finish_one();

        // Signed requests (unsigned results in the default build)
        send(-64'd7, 64'd2, 1'b1);
        wait_valid(lat);
        chk("s7_lat", 64'(lat), 64'd65);
`ifdef ALU_DIV_SIGNED_EN
        chk("s7_q", quotient, -64'd3);
        chk("s7_r", remainder, -64'd1);
`else
        chk("s7_q", quotient, 64'h7FFF_FFFF_FFFF_FFFC);
        chk("s7_r", remainder, 64'd1);
`endif
        finish_one();
        send(64'h8000_0000_0000_0000, '1, 1'b1);
        wait_valid(lat);
`ifdef ALU_DIV_SIGNED_EN
        chk("smin_q", quotient, 64'h8000_0000_0000_0000);
        chk("smin_r", remainder, 64'd0);
`else
        chk("smin_q", quotient, 64'd0);
        chk("smin_r", remainder, 64'h8000_0000_0000_0000);
`endif
        finish_one();

        // Asynchronous reset mid-RUN
        send(64'd100, 64'd7, 1'b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send(64'd9, 64'd3, 1'b0);
        wait_valid(lat);
        chk("post_rst_q", quotient, 64'd3);
        chk("post_rst_r", remainder, 64'd0);
        finish_one();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
